id_ex_register: RTL

ID_EX_REGISTER -- requirements
Module: id_ex_register

---
 rtl/rv_pipe_pkg.sv | 46 ++++
 rtl/id_ex_bypass.sv | 23 ++
 rtl/id_ex_register.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types: decoded control bundle, ALU op codes and
// register-file write-source encodings.
package rv_pipe_pkg;

  typedef enum logic [3:0] {
    AluAdd   = 4'd0,
    AluSub   = 4'd1,
    AluSll   = 4'd2,
    AluSlt   = 4'd3,
    AluSltu  = 4'd4,
    AluXor   = 4'd5,
    AluSrl   = 4'd6,
    AluSra   = 4'd7,
    AluOr    = 4'd8,
    AluAnd   = 4'd9,
    AluPassB = 4'd10
  } alu_op_e;

  // Register-file write-data source
  localparam logic [1:0] RuSrcAlu = 2'd0;
  localparam logic [1:0] RuSrcMem = 2'd1;
  localparam logic [1:0] RuSrcPc4 = 2'd2;
  localparam logic [1:0] RuSrcImm = 2'd3;

  typedef struct packed {
    alu_op_e    AluOp;
    logic       AluASrc;
    logic       AluBSrc;
    logic       RuWr;
    logic       DmWr;
    logic       DmRd;
    logic [1:0] RuDataWrSrc;
  } ctrl_t;

  // Bubble controls: no architectural side effects
  localparam ctrl_t CTRL_NOP = '{
    AluOp:       AluAdd,
    AluASrc:     1'b0,
    AluBSrc:     1'b0,
    RuWr:        1'b0,
    DmWr:        1'b0,
    DmRd:        1'b0,
    RuDataWrSrc: RuSrcAlu
  };

endpackage

// File: rtl/id_ex_bypass.sv
// Write-through mux: a register being written back this cycle is forwarded
// in place of the (stale) register-file read. x0 is never forwarded.
module id_ex_bypass #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic [RA_W-1:0] Rs,
  input  logic [XLEN-1:0] RsData,
  input  logic            WbRuWr,
  input  logic [RA_W-1:0] WbRd,
  input  logic [XLEN-1:0] WbData,
  output logic [XLEN-1:0] RsDataOut
);

  logic hit;

  // Select writeback data on an index match with a live, non-x0 write
  always_comb begin
    hit       = WbRuWr && (WbRd != '0) && (WbRd == Rs);
    RsDataOut = hit ? WbData : RsData;
  end

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with flush/stall handling, load-use hazard
// detection, write-through operand bypass and a saturating bubble counter.
module id_ex_register
  import rv_pipe_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Stall,
  input  logic            Flush,
  input  logic            IdValid,
  input  logic [XLEN-1:0] IdPc,
  input  logic [XLEN-1:0] IdImm,
  input  logic [RA_W-1:0] IdRs1,
  input  logic [RA_W-1:0] IdRs2,
  input  logic [RA_W-1:0] IdRd,
  input  logic [XLEN-1:0] IdRuRs1,
  input  logic [XLEN-1:0] IdRuRs2,
  input  ctrl_t           IdCtrl,
  input  logic            WbRuWr,
  input  logic [RA_W-1:0] WbRd,
  input  logic [XLEN-1:0] WbData,
  output logic            ExValid,
  output logic [XLEN-1:0] ExPc,
  output logic [XLEN-1:0] ExImm,
  output logic [RA_W-1:0] ExRs1,
  output logic [RA_W-1:0] ExRs2,
  output logic [RA_W-1:0] ExRd,
  output ctrl_t           ExCtrl,
  output logic [XLEN-1:0] ExRs1Data,
  output logic [XLEN-1:0] ExRs2Data,
  output logic            LoadUseStall,
  output logic [31:0]     BubbleCount
);

  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] ex_pc_q, ex_pc_d;
  logic [XLEN-1:0] ex_imm_q, ex_imm_d;
  logic [RA_W-1:0] ex_rs1_q, ex_rs1_d;
  logic [RA_W-1:0] ex_rs2_q, ex_rs2_d;
  logic [RA_W-1:0] ex_rd_q, ex_rd_d;
  ctrl_t           ex_ctrl_q, ex_ctrl_d;
  logic [XLEN-1:0] ex_rs1_data_q, ex_rs1_data_d;
  logic [XLEN-1:0] ex_rs2_data_q, ex_rs2_data_d;
  logic [31:0]     bubble_count_q, bubble_count_d;

  logic            load_use;
  logic            hold;
  logic            bubble;
  logic [RA_W-1:0] byp_rs1_idx, byp_rs2_idx;
  logic [XLEN-1:0] byp_rs1_in, byp_rs2_in;
  logic [XLEN-1:0] byp_rs1_out, byp_rs2_out;

  // Hazard detect and per-edge action decode (Rst is handled in the flop)
  always_comb begin
    load_use = ex_valid_q && ex_ctrl_q.DmRd && IdValid && (ex_rd_q != '0) &&
               ((ex_rd_q == IdRs1) || (ex_rd_q == IdRs2));
    hold     = Stall && !Flush;
    bubble   = Flush || (!Stall && load_use);
    // While holding, the bypass refreshes the held operand instead of the ID one
    byp_rs1_idx = hold ? ex_rs1_q      : IdRs1;
    byp_rs1_in  = hold ? ex_rs1_data_q : IdRuRs1;
    byp_rs2_idx = hold ? ex_rs2_q      : IdRs2;
    byp_rs2_in  = hold ? ex_rs2_data_q : IdRuRs2;
  end

  id_ex_bypass #(
    .XLEN (XLEN),
    .RA_W (RA_W)
  ) u_bypass_rs1 (
    .Rs        (byp_rs1_idx),
    .RsData    (byp_rs1_in),
    .WbRuWr    (WbRuWr),
    .WbRd      (WbRd),
    .WbData    (WbData),
    .RsDataOut (byp_rs1_out)
  );

  id_ex_bypass #(
    .XLEN (XLEN),
    .RA_W (RA_W)
  ) u_bypass_rs2 (
    .Rs        (byp_rs2_idx),
    .RsData    (byp_rs2_in),
    .WbRuWr    (WbRuWr),
    .WbRd      (WbRd),
    .WbData    (WbData),
    .RsDataOut (byp_rs2_out)
  );

  // Next EX contents: bubble, hold (with operand refresh) or capture
  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_pc_d        = ex_pc_q;
    ex_imm_d       = ex_imm_q;
    ex_rs1_d       = ex_rs1_q;
    ex_rs2_d       = ex_rs2_q;
    ex_rd_d        = ex_rd_q;
    ex_ctrl_d      = ex_ctrl_q;
    ex_rs1_data_d  = byp_rs1_out;
    ex_rs2_data_d  = byp_rs2_out;
    bubble_count_d = bubble_count_q;
    if (bubble) begin
      ex_valid_d    = 1'b0;
      ex_pc_d       = '0;
      ex_imm_d      = '0;
      ex_rs1_d      = '0;
      ex_rs2_d      = '0;
      ex_rd_d       = '0;
      ex_ctrl_d     = CTRL_NOP;
      ex_rs1_data_d = '0;
      ex_rs2_data_d = '0;
      if (bubble_count_q != 32'hFFFF_FFFF) begin
        bubble_count_d = bubble_count_q + 32'd1;
      end
    end else if (!hold) begin
      ex_valid_d = IdValid;
      ex_pc_d    = IdPc;
      ex_imm_d   = IdImm;
      ex_rs1_d   = IdRs1;
      ex_rs2_d   = IdRs2;
      ex_rd_d    = IdRd;
      ex_ctrl_d  = IdValid ? IdCtrl : CTRL_NOP;
    end
  end

  // EX stage state with synchronous reset
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ex_valid_q     <= 1'b0;
      ex_pc_q        <= '0;
      ex_imm_q       <= '0;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      ex_rd_q        <= '0;
      ex_ctrl_q      <= CTRL_NOP;
      ex_rs1_data_q  <= '0;
      ex_rs2_data_q  <= '0;
      bubble_count_q <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_pc_q        <= ex_pc_d;
      ex_imm_q       <= ex_imm_d;
      ex_rs1_q       <= ex_rs1_d;
      ex_rs2_q       <= ex_rs2_d;
      ex_rd_q        <= ex_rd_d;
      ex_ctrl_q      <= ex_ctrl_d;
      ex_rs1_data_q  <= ex_rs1_data_d;
      ex_rs2_data_q  <= ex_rs2_data_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  // Output drive
  always_comb begin
    ExValid      = ex_valid_q;
    ExPc         = ex_pc_q;
    ExImm        = ex_imm_q;
    ExRs1        = ex_rs1_q;
    ExRs2        = ex_rs2_q;
    ExRd         = ex_rd_q;
    ExCtrl       = ex_ctrl_q;
    ExRs1Data    = ex_rs1_data_q;
    ExRs2Data    = ex_rs2_data_q;
    LoadUseStall = load_use;
    BubbleCount  = bubble_count_q;
  end

endmodule
